// File: rtl/rect_draw_engine.sv
// rect_draw_engine: sweeps a latched rectangle row-major, one clipped VGA pixel per clock
module rect_draw_engine #(
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int SZ_W = 6,
  parameter int COLOUR_W = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [X_W-1:0]      x_origin,
  input  logic [Y_W-1:0]      y_origin,
  input  logic [SZ_W-1:0]     width,
  input  logic [SZ_W-1:0]     height,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                erase,
  output logic                busy,
  output logic                done,
  output logic [X_W-1:0]      x_cord,
  output logic [Y_W-1:0]      y_cord,
  output logic [COLOUR_W-1:0] colourOut,
  output logic                plot
);
  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
  state_t state, state_next;
  logic [SZ_W-1:0] x_count, y_count, w_l, h_l;
  logic [X_W-1:0] x0_l;
  logic [Y_W-1:0] y0_l;
  logic [COLOUR_W-1:0] colour_l;
  logic erase_l;
  logic [X_W:0] x_sum;
  logic [Y_W:0] y_sum;
  logic x_last, y_last;
  assign x_last = x_count == w_l - 1'b1;
  assign y_last = y_count == h_l - 1'b1;
  assign x_sum = {1'b0, x0_l} + (X_W+1)'(x_count);
  assign y_sum = {1'b0, y0_l} + (Y_W+1)'(y_count);
  assign x_cord = x_sum[X_W-1:0];
  assign y_cord = y_sum[Y_W-1:0];
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign plot = state == DRAW && x_sum < (X_W+1)'(SCREEN_W) && y_sum < (Y_W+1)'(SCREEN_H);
  assign colourOut = erase_l ? BG_COLOUR : colour_l;
  // next state: a zero-size request skips straight to DONE
  always_comb begin
    state_next = state;
    state_next = state == IDLE ? (start ? ((width != '0 && height != '0) ? DRAW : DONE) : IDLE)
               : state == DRAW ? ((x_last && y_last) ? DONE : DRAW)
               : IDLE;
  end
  // state, request latches and row-major pixel counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      x_count <= '0;
      y_count <= '0;
      x0_l <= '0;
      y0_l <= '0;
      w_l <= '0;
      h_l <= '0;
      colour_l <= '0;
      erase_l <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        x0_l <= x_origin;
        y0_l <= y_origin;
        w_l <= width;
        h_l <= height;
        colour_l <= colour;
        erase_l <= erase;
      end
      if (state == DRAW && !(x_last && y_last)) begin
        x_count <= x_last ? '0 : x_count + 1'b1;
        y_count <= x_last ? y_count + 1'b1 : y_count;
      end else begin
        x_count <= '0;
        y_count <= '0;
      end
    end
  end
endmodule

// File: tb/tb_rect_draw_engine.sv
// tb_rect_draw_engine: scoreboard bench for the rectangle fill engine
module tb_rect_draw_engine;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, erase = 1'b0;
  logic [7:0] x_origin = '0;
  logic [6:0] y_origin = '0;
  logic [5:0] width = '0, height = '0;
  logic [2:0] colour = '0;
  logic busy, done, plot;
  logic [7:0] x_cord;
  logic [6:0] y_cord;
  logic [2:0] colourOut;

  rect_draw_engine dut (
    .clk(clk), .reset(reset), .start(start), .x_origin(x_origin), .y_origin(y_origin),
    .width(width), .height(height), .colour(colour), .erase(erase), .busy(busy),
    .done(done), .x_cord(x_cord), .y_cord(y_cord), .colourOut(colourOut), .plot(plot)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; int c; int t;} pix_t;
  pix_t pq[$];
  int dq[$];
  pix_t e;
  int cyc = 0, n_chk = 0, n_pass = 0, plot_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
  endtask

  task automatic push_req(input int x0, input int y0, input int w, input int h, input int c,
                          input int er, input int t, input int npix, input bit with_done);
    for (int k = 0; k < npix; k++) begin
      int px, py;
      px = x0 + k % w;
      py = y0 + k / w;
      if (px < 160 && py < 120) pq.push_back('{px, py, er ? 0 : c, t + k});
    end
    if (with_done) dq.push_back((w == 0 || h == 0) ? t : t + w * h);
  endtask

  task automatic set_in(input int x0, input int y0, input int w, input int h, input int c, input int er);
    x_origin = 8'(x0);
    y_origin = 7'(y0);
    width = 6'(w);
    height = 6'(h);
    colour = 3'(c);
    erase = er[0];
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((pq.size() != 0 || dq.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("drain", pq.size() + dq.size(), 0);
    pq.delete();
    dq.delete();
    @(negedge clk);
    check("busy_off", int'(busy), 0);
  endtask

  task automatic send(input int x0, input int y0, input int w, input int h, input int c, input int er);
    @(negedge clk);
    set_in(x0, y0, w, h, c, er);
    start = 1'b1;
    push_req(x0, y0, w, h, c, er, cyc + 1, w * h, 1'b1);
    @(negedge clk);
    start = 1'b0;
    check("busy_on", int'(busy), 1);
    wait_idle(w * h + 8);
  endtask

  // every plotted pixel and done pulse is matched against the scoreboard
  always @(negedge clk) begin
    if (plot) begin
      plot_cnt++;
      if (pq.size() == 0) check("extra_plot", 1, 0);
      else begin
        e = pq.pop_front();
        check("px_x", int'(x_cord), e.x);
        check("px_y", int'(y_cord), e.y);
        check("px_c", int'(colourOut), e.c);
        check("px_t", cyc, e.t);
      end
    end
    if (done) begin
      if (dq.size() == 0) check("extra_done", 1, 0);
      else check("done_t", cyc, dq.pop_front());
    end
  end

  initial begin
    int p0, ta, c0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_plot", int'(plot), 0);
    check("rst_x", int'(x_cord), 0);
    check("rst_y", int'(y_cord), 0);
    check("rst_c", int'(colourOut), 0);
    reset = 1'b0;
    p0 = plot_cnt;
    send(10, 20, 4, 3, 7, 0);
    check("basic_cnt", plot_cnt - p0, 12);
    send(10, 20, 4, 3, 5, 1);
    p0 = plot_cnt;
    send(150, 115, 20, 10, 6, 0);
    check("clip_cnt", plot_cnt - p0, 50);
    p0 = plot_cnt;
    send(30, 30, 0, 5, 4, 0);
    send(30, 30, 5, 0, 4, 0);
    check("zero_cnt", plot_cnt - p0, 0);
    p0 = plot_cnt;
    @(negedge clk);
    set_in(0, 0, 40, 60, 2, 0);
    start = 1'b1;
    push_req(0, 0, 40, 60, 2, 0, cyc + 1, 2400, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    set_in(50, 30, 5, 5, 5, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(2500);
    check("busy_start_cnt", plot_cnt - p0, 2400);
    @(negedge clk);
    c0 = cyc;
    set_in(10, 20, 4, 3, 7, 0);
    start = 1'b1;
    push_req(10, 20, 4, 3, 7, 0, c0 + 1, 8, 1'b0);
    @(negedge clk);
    start = 1'b0;
    while (cyc < c0 + 8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_plot", int'(plot), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_left", pq.size(), 0);
    send(10, 20, 4, 3, 3, 0);
    @(negedge clk);
    set_in(40, 40, 3, 3, 1, 0);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("rst_start_busy", int'(busy), 0);
    repeat (5) @(negedge clk);
    check("rst_start_idle", int'(busy), 0);
    p0 = plot_cnt;
    @(negedge clk);
    set_in(5, 5, 3, 2, 1, 0);
    start = 1'b1;
    ta = cyc + 1;
    push_req(5, 5, 3, 2, 1, 0, ta, 6, 1'b1);
    @(negedge clk);
    set_in(100, 100, 2, 2, 6, 0);
    push_req(100, 100, 2, 2, 6, 0, ta + 8, 4, 1'b1);
    while (cyc < ta + 8) @(negedge clk);
    start = 1'b0;
    wait_idle(30);
    check("b2b_cnt", plot_cnt - p0, 10);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rect_draw_engine.md
Name: rect_draw_engine

Overview:
- Parametrised rectangle fill engine that feeds the VGA adapter's x/y/colour/writeEn inputs.
- Each request sets an origin, width, height, colour and erase flag. The block sweeps the rectangle row-major, one pixel per clock.
- Handshake: start/busy/done. Pixels outside the screen are suppressed (clipped).
- Sits between game-control FSMs (press/garbage placement) and the VGA adapter.

Parameters:
X_W, 8, width of x coordinate
Y_W, 7, width of y coordinate
SZ_W, 6, width of rectangle width/height inputs (max 63 pixels per side)
COLOUR_W, 3, colour width
SCREEN_W, 160, visible columns; x >= SCREEN_W is clipped
SCREEN_H, 120, visible rows; y >= SCREEN_H is clipped
BG_COLOUR, 0, colour driven when erase is latched

Ports:
clk  in  1  system clock (CLOCK_50)
reset  in  1  synchronous, active-high reset
start  in  1  request strobe; sampled only in IDLE
x_origin  in  X_W  top-left x of rectangle
y_origin  in  Y_W  top-left y of rectangle
width  in  SZ_W  rectangle width in pixels
height  in  SZ_W  rectangle height in pixels
colour  in  COLOUR_W  fill colour
erase  in  1  1: fill with BG_COLOUR; 0: fill with colour
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse when a request completes
x_cord  out  X_W  pixel x to VGA
y_cord  out  Y_W  pixel y to VGA
colourOut  out  COLOUR_W  pixel colour to VGA
plot  out  1  VGA write enable

Behaviour:
- Reset and clock: one clock (clk). reset is synchronous and active-high.
- Reset values: state=IDLE; x_count=0, y_count=0; all latched request registers 0; busy=0, done=0, plot=0, x_cord=0, y_cord=0, colourOut=0.
- States: IDLE, DRAW, DONE.
- IDLE:
  - If start=1 at edge T, latch x_origin, y_origin, width, height, colour and erase.
  - If width!=0 and height!=0, go to DRAW; otherwise go to DONE.
  - Counters are cleared to 0.
- DRAW:
  - Pixel (x_count, y_count) is presented during the cycle.
  - Advance: if x_count < w-1, x_count++. Else if y_count < h-1, x_count=0 and y_count++. Else (last pixel) go to DONE and clear counters.
  - Pixel k (row-major, k = y*w + x) appears in cycle T+1+k. The last pixel is at T+w*h.
- DONE: done=1 for exactly one cycle, then IDLE. The earliest next start is sampled in the cycle after DONE.
- start while busy (DRAW or DONE) is ignored. Input changes while busy have no effect; only latched values are used.
- Output arithmetic:
  - x_sum = x0 + x_count, computed at X_W+1 bits; y_sum = y0 + y_count, computed at Y_W+1 bits.
  - x_cord = x_sum[X_W-1:0]; y_cord = y_sum[Y_W-1:0].
  - The x_sum/y_sum/x_cord/y_cord terms are combinational from registers.
- plot = (state==DRAW) && (x_sum < SCREEN_W) && (y_sum < SCREEN_H).
  - Clipped pixels still consume their cycle, so the cycle count is always w*h.
- colourOut = erase_l ? BG_COLOUR : colour_l. This is driven in DRAW and held otherwise.
- Zero size (width=0 or height=0): no plot pulses; done asserts at T+1.
- Reset mid-operation: return to IDLE on the next edge. plot=0 and busy=0 from that edge; no done pulse is produced.
- Simultaneous reset and start: reset wins; the request is dropped.

Test Plan:
- Basic 4x3 fill. reset, then start with x0=10, y0=20, w=4, h=3, colour=3'b111, erase=0.
  - Required: plot high for 12 consecutive cycles T+1..T+12.
  - Coordinates: (10,20),(11,20),(12,20),(13,20),(10,21)...(13,22); colourOut=7.
  - done pulse at T+13; busy high T+1..T+13.
- Erase mode. Same request with erase=1 and colour=3'b101.
  - Required: colourOut=BG_COLOUR (0) on all 12 pixels.
- Clipping. x0=150, y0=115, w=20, h=10.
  - Required: 200 DRAW cycles, done at T+201.
  - plot=1 only for x_sum in 150..159 and y_sum in 115..119, i.e. exactly 50 plot pulses.
- Zero size and busy-start.
  - w=0, h=5: done at T+1, zero plot pulses.
  - During a 40x60 draw, pulse start with different origin/size: the extra start is ignored; 2400 pixels are drawn at the original origin; single done.
- Reset mid-draw.
  - Assert reset at pixel 7 of a 4x3 draw: next edge gives busy=0, plot=0, no done.
  - A fresh start then draws from (x0,y0) with counters at 0.
- Back-to-back requests.
  - Hold start=1 continuously through two requests: second request is accepted in the first IDLE cycle after DONE.
  - There is exactly one done pulse per request and no overlap of plot streams.
